// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with an internal TX FIFO.
// Ports:
//    clk_i, rst_ni         clock, asynchronous active-low reset
//    tx_en_i               new frames launch only while high
//    tx_wen_i, din_i       FIFO write strobe and data (writes while full are dropped)
//    baud_div_i            clocks per bit; 0 selects CLK_FREQ/BAUD_RATE, 1 acts as 2
//    data_bits_i           data bits per frame, clamped to 5..DATA_WIDTH
//    parity_i              00/11 none, 01 even, 10 odd
//    stop2_i               0 one stop bit, 1 two stop bits
//    empty_o, full_o       FIFO status
//    level_o               FIFO occupancy
//    busy_o                frame in progress
//    tx_done_o             high on the last clock of the final stop bit
//    tx_bit_o              registered serial output, idles high
module uart_tx_cfg #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          tx_en_i,
   input  logic                          tx_wen_i,
   input  logic [DATA_WIDTH-1:0]         din_i,
   input  logic [DIV_WIDTH-1:0]          baud_div_i,
   input  logic [3:0]                    data_bits_i,
   input  logic [1:0]                    parity_i,
   input  logic                          stop2_i,
   output logic                          empty_o,
   output logic                          full_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          busy_o,
   output logic                          tx_done_o,
   output logic                          tx_bit_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [DIV_WIDTH-1:0] DIV_DEF = DIV_WIDTH'(CLK_FREQ / BAUD_RATE);
   localparam logic [3:0] DW4 = 4'(DATA_WIDTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

   state_e                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
   logic [AW-1:0]          wr_q, rd_q;
   logic [LW-1:0]          cnt_q;
   logic [DATA_WIDTH-1:0]  data_q, data_d, mask, head;
   logic [DIV_WIDTH-1:0]   div_q, div_d, baud_q, baud_d, div_eff;
   logic [3:0]             bits_q, bits_d, idx_q, idx_d, b_eff;
   logic                   par_en_q, par_en_d, par_q, par_d, stop2_q, stop2_d, tx_q, tx_d;
   logic                   push, launch, bit_end, frame_end;

   assign empty_o   = cnt_q == '0;
   assign full_o    = cnt_q == LW'(FIFO_DEPTH);
   assign level_o   = cnt_q;
   assign busy_o    = state_q != IDLE;
   assign tx_bit_o  = tx_q;
   assign tx_done_o = frame_end;
   assign head      = mem_q[rd_q];
   assign push      = tx_wen_i && !full_o;
   // div_q holds the last baud count (D-1), so a bit ends when the counter reaches it
   assign bit_end   = state_q != IDLE && baud_q == div_q;
   // idx_q doubles as the stop-bit index once the data bits are out
   assign frame_end = state_q == STOP && bit_end && (!stop2_q || idx_q[0]);
   assign launch    = tx_en_i && !empty_o && (state_q == IDLE || frame_end);

   always_comb begin
      div_eff = baud_div_i == '0 ? DIV_DEF : baud_div_i;
      b_eff   = data_bits_i < 4'd5 ? 4'd5 : (data_bits_i > DW4 ? DW4 : data_bits_i);
      mask    = '0;
      for (int i = 0; i < DATA_WIDTH; i++) mask[i] = 4'(i) < b_eff;
   end

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      div_d    = div_q;
      bits_d   = bits_q;
      par_en_d = par_en_q;
      par_d    = par_q;
      stop2_d  = stop2_q;
      idx_d    = idx_q;
      tx_d     = tx_q;
      baud_d   = (state_q == IDLE || bit_end) ? '0 : baud_q + DIV_WIDTH'(1);
      if (launch) begin
         state_d  = START;
         data_d   = head;
         div_d    = div_eff <= DIV_WIDTH'(1) ? DIV_WIDTH'(1) : div_eff - DIV_WIDTH'(1);
         bits_d   = b_eff;
         par_en_d = parity_i[0] ^ parity_i[1];
         par_d    = (^(head & mask)) ^ parity_i[1];
         stop2_d  = stop2_i;
         idx_d    = '0;
         tx_d     = 1'b0;
         baud_d   = '0;
      end else if (bit_end) begin
         case (state_q)
            START: begin
               state_d = DATA;
               tx_d    = data_q[0];
               data_d  = data_q >> 1;
            end
            DATA: begin
               if (idx_q == bits_q - 4'd1) begin
                  state_d = par_en_q ? PARITY : STOP;
                  tx_d    = par_en_q ? par_q : 1'b1;
                  idx_d   = '0;
               end else begin
                  idx_d  = idx_q + 4'd1;
                  tx_d   = data_q[0];
                  data_d = data_q >> 1;
               end
            end
            PARITY: begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
            STOP: begin
               state_d = frame_end ? IDLE : STOP;
               idx_d   = idx_q + 4'd1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) if (push) mem_q[wr_q] <= din_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q     <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         state_q  <= IDLE;
         data_q   <= '0;
         div_q    <= DIV_WIDTH'(1);
         bits_q   <= 4'd5;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         stop2_q  <= 1'b0;
         idx_q    <= '0;
         baud_q   <= '0;
         tx_q     <= 1'b1;
      end else begin
         wr_q     <= wr_q + AW'(push);
         rd_q     <= rd_q + AW'(launch);
         cnt_q    <= cnt_q + LW'(push) - LW'(launch);
         state_q  <= state_d;
         data_q   <= data_d;
         div_q    <= div_d;
         bits_q   <= bits_d;
         par_en_q <= par_en_d;
         par_q    <= par_d;
         stop2_q  <= stop2_d;
         idx_q    <= idx_d;
         baud_q   <= baud_d;
         tx_q     <= tx_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: self-checking bench for uart_tx_cfg against a bit-list frame model.
module tb_uart_tx_cfg;
   localparam int CLK_HZ = 50_000_000;
   localparam int BAUD   = 115_200;

   logic        clk_i, rst_ni, tx_en_i, tx_wen_i, stop2_i;
   logic [7:0]  din_i;
   logic [15:0] baud_div_i;
   logic [3:0]  data_bits_i;
   logic [1:0]  parity_i;
   logic        empty_o, full_o, busy_o, tx_done_o, tx_bit_o;
   logic [4:0]  level_o;
   int          n_cmp = 0;
   int          n_err = 0;

   uart_tx_cfg #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_WIDTH(8), .FIFO_DEPTH(16), .DIV_WIDTH(16)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .tx_en_i(tx_en_i), .tx_wen_i(tx_wen_i), .din_i(din_i),
      .baud_div_i(baud_div_i), .data_bits_i(data_bits_i), .parity_i(parity_i), .stop2_i(stop2_i),
      .empty_o(empty_o), .full_o(full_o), .level_o(level_o), .busy_o(busy_o),
      .tx_done_o(tx_done_o), .tx_bit_o(tx_bit_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [7:0] d);
      din_i    = d;
      tx_wen_i = 1'b1;
      @(negedge clk_i);
      tx_wen_i = 1'b0;
   endtask

   // Expected frame: start, B data bits LSB first, optional parity, 1 or 2 stops, each D clocks.
   // kind 1 changes the divisor/parity at cycle chg_at, kind 2 drops tx_en_i there.
   task automatic check_frame(input logic [7:0] data, input int div_in, input int db, input int par,
                              input int st2, input int chg_at, input int kind, input int lvl);
      bit eb[$];
      int d, b, ones, len;
      d = (div_in == 0) ? CLK_HZ / BAUD : div_in;
      if (d == 1) d = 2;
      b = db < 5 ? 5 : (db > 8 ? 8 : db);
      ones = 0;
      eb.push_back(1'b0);
      for (int i = 0; i < b; i++) begin
         eb.push_back(data[i]);
         ones += int'(data[i]);
      end
      if (par == 1) eb.push_back(bit'(ones % 2));
      else if (par == 2) eb.push_back(bit'(1 - ones % 2));
      eb.push_back(1'b1);
      if (st2 != 0) eb.push_back(1'b1);
      len = d * eb.size();
      for (int c = 1; c <= len; c++) begin
         @(negedge clk_i);
         chk("tx_bit", 32'(tx_bit_o), 32'(eb[(c - 1) / d]));
         chk("tx_done", 32'(tx_done_o), 32'(c == len));
         chk("busy", 32'(busy_o), 32'd1);
         if (c == 1) chk("level", 32'(level_o), lvl);
         if (c == chg_at) begin
            if (kind == 1) begin
               baud_div_i = 16'd8;
               parity_i   = 2'b01;
            end else tx_en_i = 1'b0;
         end
      end
   endtask

   initial begin
      logic [7:0] rd;
      int rdiv, rdb, rpar, rst2;
      rst_ni = 1'b0; tx_en_i = 1'b0; tx_wen_i = 1'b0; din_i = '0;
      baud_div_i = 16'd4; data_bits_i = 4'd8; parity_i = 2'b00; stop2_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("rst_tx", 32'(tx_bit_o), 1);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_done", 32'(tx_done_o), 0);
      chk("rst_empty", 32'(empty_o), 1);
      chk("rst_full", 32'(full_o), 0);
      chk("rst_level", 32'(level_o), 0);
      rst_ni = 1'b1;
      @(negedge clk_i);
      // 8N1 0xA5, D=4
      wr(8'hA5);
      chk("lvl_one", 32'(level_o), 1);
      chk("not_empty", 32'(empty_o), 0);
      tx_en_i = 1'b1;
      check_frame(8'hA5, 4, 8, 0, 0, 0, 0, 0);
      @(negedge clk_i);
      chk("idle_busy", 32'(busy_o), 0);
      chk("idle_tx", 32'(tx_bit_o), 1);
      // 7 bits, parity, two stops; bit 7 of 0xC1 must not matter
      data_bits_i = 4'd7; parity_i = 2'b01; stop2_i = 1'b1;
      wr(8'h41); check_frame(8'h41, 4, 7, 1, 1, 0, 0, 0);
      wr(8'hC1); check_frame(8'hC1, 4, 7, 1, 1, 0, 0, 0);
      parity_i = 2'b10;
      wr(8'h41); check_frame(8'h41, 4, 7, 2, 1, 0, 0, 0);
      // back-to-back frames
      tx_en_i = 1'b0; data_bits_i = 4'd8; parity_i = 2'b00; stop2_i = 1'b0;
      wr(8'h11); wr(8'h22); wr(8'h33);
      chk("lvl_three", 32'(level_o), 3);
      tx_en_i = 1'b1;
      check_frame(8'h11, 4, 8, 0, 0, 0, 0, 2);
      check_frame(8'h22, 4, 8, 0, 0, 0, 0, 1);
      check_frame(8'h33, 4, 8, 0, 0, 0, 0, 0);
      chk("b2b_empty", 32'(empty_o), 1);
      @(negedge clk_i);
      chk("b2b_idle", 32'(busy_o), 0);
      // fill to full, overflow dropped
      tx_en_i = 1'b0; baud_div_i = 16'd2;
      for (int i = 0; i < 17; i++) begin
         wr(8'(i));
         if (i == 14) begin
            chk("full_15", 32'(full_o), 0);
            chk("lvl_15", 32'(level_o), 15);
         end
      end
      chk("full_set", 32'(full_o), 1);
      chk("lvl_16", 32'(level_o), 16);
      tx_en_i = 1'b1;
      for (int i = 0; i < 16; i++) check_frame(8'(i), 2, 8, 0, 0, 0, 0, 15 - i);
      @(negedge clk_i);
      chk("drain_empty", 32'(empty_o), 1);
      chk("drain_busy", 32'(busy_o), 0);
      // mid-frame config change applies to the next frame only
      tx_en_i = 1'b0; baud_div_i = 16'd4;
      wr(8'h5A); wr(8'hC3);
      tx_en_i = 1'b1;
      check_frame(8'h5A, 4, 8, 0, 0, 17, 1, 1);
      check_frame(8'hC3, 8, 8, 1, 0, 0, 0, 0);
      // dropping tx_en_i mid-frame finishes the frame, then idles
      baud_div_i = 16'd3; parity_i = 2'b00; tx_en_i = 1'b0;
      wr(8'hE7); wr(8'h18);
      tx_en_i = 1'b1;
      check_frame(8'hE7, 3, 8, 0, 0, 7, 2, 1);
      repeat (5) begin
         @(negedge clk_i);
         chk("hold_busy", 32'(busy_o), 0);
         chk("hold_tx", 32'(tx_bit_o), 1);
         chk("hold_lvl", 32'(level_o), 1);
      end
      tx_en_i = 1'b1;
      check_frame(8'h18, 3, 8, 0, 0, 0, 0, 0);
      // divisor 1 behaves as 2
      baud_div_i = 16'd1;
      wr(8'h9C); check_frame(8'h9C, 1, 8, 0, 0, 0, 0, 0);
      // randomized frames, including out-of-range data_bits_i
      for (int k = 0; k < 24; k++) begin
         rd = 8'($urandom_range(0, 255));
         rdiv = int'($urandom_range(1, 6));
         rdb = int'($urandom_range(0, 15));
         rpar = int'($urandom_range(0, 3));
         rst2 = int'($urandom_range(0, 1));
         baud_div_i = 16'(rdiv); data_bits_i = 4'(rdb); parity_i = 2'(rpar); stop2_i = rst2[0];
         wr(rd);
         check_frame(rd, rdiv, rdb, rpar, rst2, 0, 0, 0);
      end
      // default divisor
      baud_div_i = 16'd0; data_bits_i = 4'd5; parity_i = 2'b10; stop2_i = 1'b1;
      wr(8'h6B); check_frame(8'h6B, 0, 5, 2, 1, 0, 0, 0);
      // asynchronous reset mid-frame
      baud_div_i = 16'd4; data_bits_i = 4'd8; parity_i = 2'b00; stop2_i = 1'b0; tx_en_i = 1'b0;
      wr(8'h00); wr(8'h01); wr(8'h02);
      tx_en_i = 1'b1;
      repeat (10) @(negedge clk_i);
      chk("pre_rst_busy", 32'(busy_o), 1);
      rst_ni = 1'b0;
      #1;
      chk("arst_tx", 32'(tx_bit_o), 1);
      chk("arst_busy", 32'(busy_o), 0);
      chk("arst_done", 32'(tx_done_o), 0);
      chk("arst_empty", 32'(empty_o), 1);
      chk("arst_level", 32'(level_o), 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("post_rst_busy", 32'(busy_o), 0);
      chk("post_rst_tx", 32'(tx_bit_o), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Runtime-configurable UART transmitter with an internal FIFO. It is the parametrised successor of the fixed 8N1 transmitter. Frame format is selectable per frame: data bit count, parity mode, stop bit count, and baud divisor. It adds level, busy and frame-done status, and sits between a register/bus interface and the serial TX pin.

Parameters:
CLK_FREQ, 50_000_000, system clock in Hz.
BAUD_RATE, 115_200, default baud used when baud_div_i == 0.
DATA_WIDTH, 8, maximum data bits per frame; legal range 5..9.
FIFO_DEPTH, 16, TX FIFO entries; power of two, >= 2.
DIV_WIDTH, 16, width of runtime baud divisor.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset.
tx_en_i  in  1  transmit enable; new frames start only while high.
tx_wen_i  in  1  FIFO write strobe.
din_i  in  DATA_WIDTH  write data.
baud_div_i  in  DIV_WIDTH  clocks per bit; 0 selects CLK_FREQ/BAUD_RATE.
data_bits_i  in  4  data bits per frame.
parity_i  in  2  00 none, 01 even, 10 odd, 11 none.
stop2_i  in  1  0 = one stop bit, 1 = two stop bits.
empty_o  out  1  FIFO empty.
full_o  out  1  FIFO full.
level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
busy_o  out  1  frame in progress.
tx_done_o  out  1  one-cycle pulse at frame end.
tx_bit_o  out  1  serial output.

Behaviour:
- Reset: clk_i, rst_ni; asynchronous, active-low.
  - Outputs at reset: tx_bit_o=1, busy_o=0, tx_done_o=0, empty_o=1, full_o=0, level_o=0.
  - FIFO pointers and bit/baud counters cleared. Reset mid-frame aborts the frame; the line goes high at once.
- FIFO: internal circular buffer.
  - Write when tx_wen_i && !full_o.
  - Write while full is dropped, even if a pop occurs in the same cycle.
  - Simultaneous push and pop with non-empty FIFO leaves level_o unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- States: IDLE, START, DATA, PARITY, STOP.
- Frame launch: in IDLE with tx_en_i && !empty_o, at clock edge k:
  - pop the head into data_reg;
  - latch effective divisor D, bit count B, parity mode, stop count;
  - enter START. tx_bit_o is low from edge k.
- Per-frame configuration:
  - D = baud_div_i, or CLK_FREQ/BAUD_RATE if baud_div_i is 0; D = 1 is treated as 2.
  - B = data_bits_i clamped to 5..DATA_WIDTH.
  - Config input changes mid-frame are ignored until the next launch.
- Bit timing: every bit lasts exactly D clocks, counted by a baud counter 0..D-1.
- Transitions (all at baud counter == D-1):
  - START → DATA.
  - DATA → PARITY or STOP after bit B-1; data is sent LSB first.
  - PARITY → STOP.
  - STOP → next frame after 1 or 2 bit times.
- Parity: computed over data_reg[B-1:0] only.
  - Even: total ones, including the parity bit, is even. Odd: total ones is odd.
  - Data bits above B are never transmitted.
- tx_bit_o is registered and changes only at bit boundaries. Values: START 0, DATA data bit, PARITY parity, STOP 1, IDLE 1.
- Frame end, on the last clock of the final stop bit:
  - tx_done_o pulses.
  - If tx_en_i && !empty_o: pop and go straight to START, with no idle clock between frames.
  - Otherwise go to IDLE.
- busy_o = (state != IDLE).
- Deasserting tx_en_i mid-frame: the current frame completes; no new frame launches.
- Frame length in clocks: D × (1 + B + P + S), where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).

Test Plan:
1. Reset: assert rst_ni=0 mid-operation → tx_bit_o=1, busy_o=0, empty_o=1, level_o=0, tx_done_o=0 immediately.
2. 8N1, baud_div_i=4, write 0xA5, tx_en_i=1 → tx_bit_o sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks; 40 clocks total; tx_done_o high on clock 40 only.
3. B=7, even parity, stop2_i=1, D=4, write 0x41 → bits 0,1,0,0,0,0,0,1,0(parity),1,1 over 44 clocks. With odd parity the parity bit is 1. Writing 0xC1 produces an identical frame.
4. Back-to-back: write 0x11,0x22,0x33 with tx_en_i=1 → three frames with no gap (stop bit followed directly by start bit); level_o steps 3→2→1→0; empty_o=1 after the third pop; busy_o stays high until the third stop bit ends.
5. Full: tx_en_i=0, write 17 words 0x00..0x10 → full_o=1 after the 16th write, level_o=16, 0x10 dropped. Then set tx_en_i=1 → 16 frames carrying 0x00..0x0F in order.
6. Mid-frame changes: during DATA bit 3, change baud_div_i to 8 and parity_i to 01 → current frame keeps D=4, no parity; the next frame uses D=8 with even parity. Dropping tx_en_i mid-frame → frame completes, then IDLE.
